// File: rtl/cam_dvp_source.sv
// Synthesizable DVP camera source: derives cam_xclk = clk/2 and emits framed test
// patterns (vsync/href/data) with programmable horizontal and vertical blanking.
module cam_dvp_source #(
    parameter int H_ACTIVE     = 80,
    parameter int H_BLANK      = 16,
    parameter int V_SYNC_LINES = 3,
    parameter int V_BACK       = 2,
    parameter int V_ACTIVE     = 60,
    parameter int V_FRONT      = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [7:0]  const_byte,
    output logic        cam_xclk,
    output logic        cam_vsync,
    output logic        cam_href,
    output logic [7:0]  cam_dat,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    // state  | meaning
    // IDLE   | no frame in progress, bus low, waiting for enable
    // VSYNC  | vsync high for V_SYNC_LINES line periods
    // VBACK  | blank line periods after vsync (skipped when V_BACK = 0)
    // ACTIVE | V_ACTIVE lines, href high for the first H_ACTIVE ticks of each
    // VFRONT | blank line periods before frame end (skipped when V_FRONT = 0)

    localparam int L        = H_ACTIVE + H_BLANK;
    localparam int MAX_SB   = (V_SYNC_LINES > V_BACK) ? V_SYNC_LINES : V_BACK;
    localparam int MAX_AF   = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int LINE_MAX = (MAX_SB > MAX_AF) ? MAX_SB : MAX_AF;
    localparam int COL_W    = (L > 1) ? $clog2(L) : 1;
    localparam int LINE_W   = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_t;

    state_t            state;
    state_t            n_state;
    logic [COL_W-1:0]  col_cnt;
    logic [COL_W-1:0]  n_col;
    logic [LINE_W-1:0] line_cnt;
    logic [LINE_W-1:0] n_line;
    logic [1:0]        mode_q;
    logic [1:0]        n_mode;
    logic [7:0]        fnum_q;
    logic [7:0]        n_fnum;
    logic [15:0]       fc_next;
    logic              frame_end;
    logic              frame_start;
    logic              n_href;
    logic [7:0]        n_dat;
    int                state_lines;

    // Next bus position: everything here describes the tick period being entered.
    always_comb begin
        n_state   = state;
        n_col     = col_cnt;
        n_line    = line_cnt;
        frame_end = 1'b0;
        case (state)
            VSYNC:   state_lines = V_SYNC_LINES;
            VBACK:   state_lines = V_BACK;
            ACTIVE:  state_lines = V_ACTIVE;
            VFRONT:  state_lines = V_FRONT;
            default: state_lines = 1;
        endcase

        if (state == IDLE) begin
            n_col  = '0;
            n_line = '0;
            if (enable) n_state = VSYNC;
        end else if (int'(col_cnt) != L - 1) begin
            n_col = col_cnt + COL_W'(1);
        end else begin
            n_col = '0;
            if (int'(line_cnt) != state_lines - 1) begin
                n_line = line_cnt + LINE_W'(1);
            end else begin
                n_line = '0;
                case (state)
                    VSYNC:   n_state = (V_BACK > 0) ? VBACK : ACTIVE;
                    VBACK:   n_state = ACTIVE;
                    ACTIVE: begin
                        if (V_FRONT > 0) n_state = VFRONT;
                        else             frame_end = 1'b1;
                    end
                    default: frame_end = 1'b1;
                endcase
                if (frame_end) n_state = enable ? VSYNC : IDLE;
            end
        end

        frame_start = (n_state == VSYNC) && ((state == IDLE) || frame_end);
        fc_next     = frame_end ? frame_count + 16'd1 : frame_count;
        n_mode      = frame_start ? mode : mode_q;
        // Frame-number pattern shows the count including the frame just finished.
        n_fnum      = frame_start ? fc_next[7:0] : fnum_q;
        n_href      = (n_state == ACTIVE) && (int'(n_col) < H_ACTIVE);

        case (n_mode)
            2'd0:    n_dat = 8'(int'(n_col) + int'(n_line));
            2'd1:    n_dat = const_byte;
            2'd2:    n_dat = n_fnum;
            default: n_dat = (((int'(n_col) ^ int'(n_line)) & 8) != 0) ? 8'hFF : 8'h00;
        endcase
        if (!n_href) n_dat = '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cam_xclk    <= 1'b0;
            cam_vsync   <= 1'b0;
            cam_href    <= 1'b0;
            cam_dat     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            state       <= IDLE;
            col_cnt     <= '0;
            line_cnt    <= '0;
            mode_q      <= '0;
            fnum_q      <= '0;
        end else begin
            cam_xclk   <= ~cam_xclk;
            frame_done <= 1'b0;
            // A tick is the edge on which cam_xclk falls.
            if (cam_xclk) begin
                state       <= n_state;
                col_cnt     <= n_col;
                line_cnt    <= n_line;
                mode_q      <= n_mode;
                fnum_q      <= n_fnum;
                frame_count <= fc_next;
                frame_done  <= frame_end;
                cam_vsync   <= (n_state == VSYNC);
                cam_href    <= n_href;
                cam_dat     <= n_dat;
            end
        end
    end
endmodule

// File: tb/tb_cam_dvp_source.sv
// Bench for cam_dvp_source: directed scenarios with randomized values, checked
// tick by tick against an arithmetic frame model.
module tb_cam_dvp_source;
    localparam int HA = 4;
    localparam int HB = 2;
    localparam int VS = 1;
    localparam int VA = 2;
    localparam int L  = HA + HB;

    logic       clk = 1'b0;
    logic       rst0, rst1, en0, en1;
    logic [1:0] mode;
    logic [7:0] const_byte;

    logic        xclk0, vs0, hr0, fd0, xclk1, vs1, hr1, fd1;
    logic [7:0]  dat0, dat1;
    logic [15:0] fc0, fc1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frame_end_cyc = 0;
    logic [15:0] exp_fc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cam_dvp_source #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC_LINES(VS), .V_BACK(1),
                     .V_ACTIVE(VA), .V_FRONT(1)) u0 (
        .clk(clk), .resetn(rst0), .enable(en0), .mode(mode), .const_byte(const_byte),
        .cam_xclk(xclk0), .cam_vsync(vs0), .cam_href(hr0), .cam_dat(dat0),
        .frame_done(fd0), .frame_count(fc0));

    cam_dvp_source #(.H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC_LINES(VS), .V_BACK(0),
                     .V_ACTIVE(VA), .V_FRONT(0)) u1 (
        .clk(clk), .resetn(rst1), .enable(en1), .mode(mode), .const_byte(const_byte),
        .cam_xclk(xclk1), .cam_vsync(vs1), .cam_href(hr1), .cam_dat(dat1),
        .frame_done(fd1), .frame_count(fc1));

    // {xclk, frame_done, vsync, href, dat}
    function automatic logic [11:0] obs(input bit w);
        return w ? {xclk1, fd1, vs1, hr1, dat1} : {xclk0, fd0, vs0, hr0, dat0};
    endfunction

    function automatic logic [15:0] fc_of(input bit w);
        return w ? fc1 : fc0;
    endfunction

    // Expected {vsync, href, dat} for tick t of a frame, straight from the frame layout.
    function automatic logic [9:0] model(input int t, input int md, input logic [7:0] fnum,
                                         input logic [7:0] cb, input int vb);
        int p = t / L;
        int c = t % L;
        int row;
        logic vs = 1'b0;
        logic hr = 1'b0;
        logic [7:0] d = 8'h00;
        if (p < VS) begin
            vs = 1'b1;
        end else if (p >= VS + vb && p < VS + vb + VA) begin
            row = p - VS - vb;
            if (c < HA) begin
                hr = 1'b1;
                case (md)
                    0:       d = 8'((c + row) % 256);
                    1:       d = cb;
                    2:       d = fnum;
                    default: d = (((c ^ row) >> 3) & 1) != 0 ? 8'hFF : 8'h00;
                endcase
            end
        end
        return {vs, hr, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic next_tick(input bit w);
        int n = 0;
        logic [11:0] o;
        do begin
            @(posedge clk); #1;
            n++;
            o = obs(w);
        end while (o[11] !== 1'b0 && n < 4);
        check("tick_sync", 32'(o[11]), 0);
    endtask

    task automatic wait_vsync(input bit w);
        int n = 0;
        logic [11:0] o;
        do begin
            @(posedge clk); #1;
            n++;
            o = obs(w);
        end while (o[9] !== 1'b1 && n < 8);
        check("start_latency_le2", 32'(n <= 2), 1);
        check("start_on_tick", 32'(o[11]), 0);
    endtask

    task automatic idle_ticks(input bit w, input int n);
        logic [11:0] o;
        for (int i = 0; i < n; i++) begin
            next_tick(w);
            o = obs(w);
            check("stays_idle", 32'(o[10:0]), 0);
        end
    endtask

    // Called at the sample of the tick where vsync rose; returns one clk after frame end.
    task automatic check_frame(input bit w, input int md, input int vb, input int vf,
                               input int ev_t, input logic [1:0] ev_mode,
                               input logic [7:0] ev_const, input logic ev_en);
        int total = (VS + vb + VA + vf) * L;
        logic [7:0] fnum = exp_fc[w][7:0];
        logic [11:0] o;
        for (int t = 0; t < total; t++) begin
            if (t > 0) next_tick(w);
            o = obs(w);
            check($sformatf("bus_w%0d_m%0d_t%0d", w, md, t), 32'(o[9:0]),
                  32'(model(t, md, fnum, const_byte, vb)));
            if (t > 0) check($sformatf("done_low_t%0d", t), 32'(o[10]), 0);
            if (t == ev_t) begin
                mode       = ev_mode;
                const_byte = ev_const;
                if (w) en1 = ev_en;
                else   en0 = ev_en;
            end
        end
        next_tick(w);
        exp_fc[w] = exp_fc[w] + 16'd1;
        o = obs(w);
        check("frame_done", 32'(o[10]), 1);
        check("frame_count", 32'(fc_of(w)), 32'(exp_fc[w]));
        check("vsync_after_end", 32'(o[9]), 32'(w ? en1 : en0));
        frame_end_cyc = cyc;
        @(posedge clk); #1;
        o = obs(w);
        check("done_one_clk", 32'(o[10]), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] o;
        logic        exp_x;
        logic [7:0]  c;
        int          start_cyc, end0;
        int          md, nxt;

        rst0 = 1'b1; rst1 = 1'b1; en0 = 1'b0; en1 = 1'b0;
        mode = 2'd0; const_byte = 8'h00;
        exp_fc[0] = 16'd0; exp_fc[1] = 16'd0;

        // Reset and idle
        #2 rst0 = 1'b0; rst1 = 1'b0;
        #1;
        check("reset_bus_u0", 32'(obs(0)), 0);
        check("reset_bus_u1", 32'(obs(1)), 0);
        check("reset_fc_u0", 32'(fc0), 0);
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1;
        exp_x = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            exp_x = ~exp_x;
            o = obs(0);
            check("idle_xclk", 32'(o[11]), 32'(exp_x));
            check("idle_quiet", 32'(o[10:0]), 0);
        end
        check("idle_fc", 32'(fc0), 0);

        // Single frame, ramp
        mode = 2'd0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 en0 = 1'b1;
        wait_vsync(0);
        en0 = 1'b0;
        check_frame(0, 0, 1, 1, -1, 2'd0, const_byte, 1'b0);
        idle_ticks(0, 8);

        // Continuous frames, frame-number pattern, from a fresh reset
        @(negedge clk) rst0 = 1'b0;
        #1 rst0 = 1'b1;
        exp_fc[0] = 16'd0;
        mode = 2'd2;
        en0 = 1'b1;
        wait_vsync(0);
        start_cyc = cyc;
        check_frame(0, 2, 1, 1, -1, 2'd2, const_byte, 1'b1);
        end0 = frame_end_cyc;
        check("vsync_period_0", 32'(end0 - start_cyc), 60);
        check_frame(0, 2, 1, 1, -1, 2'd2, const_byte, 1'b1);
        check("vsync_period_1", 32'(frame_end_cyc - end0), 60);
        check_frame(0, 2, 1, 1, 0, 2'd2, const_byte, 1'b0);
        check("fc_after_three", 32'(fc0), 3);

        // Constant pattern with mid-frame mode and const_byte change
        c = 8'($urandom);
        if (c == 8'hA5) c = 8'h5A;
        mode = 2'd1; const_byte = 8'hA5;
        en0 = 1'b1;
        wait_vsync(0);
        check_frame(0, 1, 1, 1, 13, 2'd0, c, 1'b1);
        check_frame(0, 0, 1, 1, 0, 2'd0, const_byte, 1'b0);

        // Enable dropped during VBACK: frame completes, then idle
        mode = 2'd3;
        en0 = 1'b1;
        wait_vsync(0);
        check_frame(0, 3, 1, 1, 8, 2'd3, const_byte, 1'b0);
        idle_ticks(0, 10);

        // Asynchronous reset during ACTIVE
        mode = 2'd0;
        en0 = 1'b1;
        wait_vsync(0);
        for (int t = 1; t <= 13; t++) next_tick(0);
        o = obs(0);
        check("href_before_reset", 32'(o[9:0]), 32'(model(13, 0, 8'h00, 8'h00, 1)));
        #1 rst0 = 1'b0;
        #1;
        check("async_reset_bus", 32'(obs(0)), 0);
        check("async_reset_fc", 32'(fc0), 0);
        #1 rst0 = 1'b1;
        en0 = 1'b0;
        exp_fc[0] = 16'd0;

        // Zero vertical blanking and frame_count wrap
        force u1.frame_count = 16'hFFFF;
        @(posedge clk); #1;
        release u1.frame_count;
        exp_fc[1] = 16'hFFFF;
        mode = 2'd2;
        en1 = 1'b1;
        wait_vsync(1);
        check_frame(1, 2, 0, 0, -1, 2'd2, const_byte, 1'b1);
        check("wrapped_fc", 32'(fc1), 0);
        check_frame(1, 2, 0, 0, 0, 2'd2, const_byte, 1'b0);

        // Randomized back-to-back frames with mid-frame changes
        md = int'($urandom_range(0, 3));
        mode = 2'(md);
        const_byte = 8'($urandom);
        en0 = 1'b1;
        wait_vsync(0);
        for (int k = 0; k < 4; k++) begin
            nxt = int'($urandom_range(0, 3));
            check_frame(0, md, 1, 1, int'($urandom_range(1, 29)), 2'(nxt),
                        8'($urandom), (k < 3));
            md = nxt;
        end
        idle_ticks(0, 4);
        check("random_fc", 32'(fc0), 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_dvp_source.md
# cam_dvp_source

Synthesizable DVP camera source that drives the same 8-bit parallel bus (xclk, vsync, href, data) the camera capture path samples, so the capture pipeline can run on hardware and in simulation without an attached sensor. It generates the pixel clock from the system clock and emits framed test patterns with programmable blanking. The whole frame sequence is driven by one state machine.

## Interface
Parameters:
- H_ACTIVE, 80: data bytes per line (href high), >=1
- H_BLANK, 16: blank ticks per line (href low), >=1
- V_SYNC_LINES, 3: line periods with vsync high, >=1
- V_BACK, 2: blank line periods after vsync, >=0
- V_ACTIVE, 60: active lines per frame, >=1
- V_FRONT, 2: blank line periods after active lines, >=0

Ports:
- clk  in  1  system clock; every register is clocked on its rising edge
- resetn  in  1  asynchronous active-low reset
- enable  in  1  request frames; level-sensitive
- mode  in  2  pattern select, sampled at frame start
- const_byte  in  8  data value for mode 1
- cam_xclk  out  1  emitted pixel clock, clk/2
- cam_vsync  out  1  frame sync, active high
- cam_href  out  1  line valid, active high
- cam_dat  out  8  pixel byte
- frame_done  out  1  one-clk pulse at the end of each frame
- frame_count  out  16  count of completed frames, wraps

## Operation
- cam_xclk is a toggle register: it starts at 0 and inverts on every clk.
- A tick is a clk edge on which cam_xclk goes 1->0. Outputs cam_vsync, cam_href and cam_dat change only on ticks.
- The sink samples on the rising edge of cam_xclk. Data is therefore stable for one clk on each side of that edge.
- A line period is L = H_ACTIVE+H_BLANK ticks. A column counter runs 0..L-1. A line counter counts line periods within the current state.
- States and transitions. Every transition happens on a tick.
  - IDLE -> VSYNC when enable=1. On this tick, latch mode into mode_q.
  - VSYNC: vsync=1, href=0, dat=0. Lasts V_SYNC_LINES*L ticks, then -> VBACK.
  - VBACK: all outputs low. Lasts V_BACK*L ticks, then -> ACTIVE. If V_BACK=0, skip directly to ACTIVE.
  - ACTIVE: for V_ACTIVE lines, href=1 while col<H_ACTIVE, else href=0 and dat=0. Then -> VFRONT. If V_FRONT=0, skip to the frame-end handling below.
  - VFRONT: all outputs low. Lasts V_FRONT*L ticks. Then frame end occurs.
  - At frame end, go -> VSYNC if enable=1 (relatch mode), else -> IDLE.
- Patterns, while href=1, with col = byte index and row = active line index:
  - 0 (ramp): dat = (col+row) mod 256.
  - 1 (constant): dat = const_byte, sampled live on each tick.
  - 2 (frame number): dat = frame_count[7:0], frozen at frame start.
  - 3 (checker): dat = (col[3]^row[3]) ? 8'hFF : 8'h00.
- Enable deasserted mid-frame: the current frame completes normally, then the block goes to IDLE. No truncated frames are ever emitted.
- Frame end: at the last tick of the frame, frame_done pulses for one clk and frame_count increments, wrapping 16'hFFFF -> 0.
- mode changes mid-frame are ignored until the next frame start.

## Timing
- Reset values: cam_xclk=0, cam_vsync=0, cam_href=0, cam_dat=0, frame_done=0, frame_count=0, state=IDLE. All counters reset to 0.
- Reset is asynchronous. Asserting it mid-frame forces all outputs low immediately.
- After resetn releases, the first tick is the 2nd clk edge.
- Start latency: cam_vsync rises on the first tick at which enable=1 is seen. That is at most 2 clk after enable rises.
- Frame length: (V_SYNC_LINES+V_BACK+V_ACTIVE+V_FRONT)*L ticks = 2x that in clk.
- Back-to-back frames have no gap: vsync rises on the tick right after the last VFRONT tick.
- Counter widths: $clog2 of each maximum count, minimum 1 bit.

## Test plan
All scenarios use H_ACTIVE=4, H_BLANK=2, V_SYNC_LINES=1, V_BACK=1, V_ACTIVE=2, V_FRONT=1 unless noted. This gives L=6 and a 30-tick (60-clk) frame.

- Reset/idle: resetn=0, then release with enable=0 for 100 clk -> cam_xclk toggles every clk; vsync, href, dat, frame_done all stay 0; frame_count=0.
- Single frame, mode 0: pulse enable high until vsync rises.
  - vsync is high for 6 ticks.
  - href is high for 4 ticks on each of 2 lines; line 0 dat=00,01,02,03 and line 1 dat=01,02,03,04.
  - frame_done pulses once, 30 ticks after vsync rose; frame_count=1; state returns to IDLE.
- Continuous frames, mode 2: hold enable=1 for 3 frames.
  - Active bytes are 00 in frame 0, 01 in frame 1, 02 in frame 2.
  - Vsync periods are exactly 60 clk apart.
  - frame_count=3.
- Mode 1 with a mid-frame change: const_byte=8'hA5 and mode=1. Switch mode to 0 during ACTIVE.
  - The current frame stays A5; the next frame is the ramp.
  - Changing const_byte mid-line takes effect on the next tick.
- Mid-frame enable drop and reset:
  - Drop enable during VBACK -> the full frame still completes, then the block goes to IDLE.
  - Assert resetn=0 during ACTIVE -> all outputs go to 0 asynchronously, before the next clk edge.
- Zero blanking: V_BACK=0, V_FRONT=0, wrap check.
  - The ACTIVE state starts right after VSYNC, and vsync re-rises right after the last active line.
  - Preload frame_count=16'hFFFF via force -> it wraps to 0 at frame_done.
